// File: rtl/cordic_rr_sched.sv
// Round-robin scheduler that shares one CORDIC rotation engine between
// N_REQ requesters. It accepts one job at a time, pulses the engine start,
// waits for done (bounded by TMO cycles), then returns the tagged result.
module cordic_rr_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 16,
  parameter int TMO   = 64
) (
  input  logic                       CLK_50M,
  input  logic                       RST_N,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W-1:0]         req_x,
  input  logic [N_REQ*W-1:0]         req_y,
  input  logic [N_REQ*W-1:0]         req_phase,
  output logic                       cor_start,
  output logic [W-1:0]               cor_x,
  output logic [W-1:0]               cor_y,
  output logic [W-1:0]               cor_phase,
  input  logic                       cor_done,
  input  logic [W-1:0]               cor_xo,
  input  logic [W-1:0]               cor_yo,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [W-1:0]               rsp_x,
  output logic [W-1:0]               rsp_y,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TMO);
  localparam logic [ID_W:0]    SUM_N   = (ID_W+1)'(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TMO - 1);
  localparam logic [ID_W-1:0]  ID_LAST = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   ptr_reg;
  logic [ID_W-1:0]   gid_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              cor_start_reg;
  logic [W-1:0]      cor_x_reg;
  logic [W-1:0]      cor_y_reg;
  logic [W-1:0]      cor_phase_reg;
  logic              rsp_valid_reg;
  logic [W-1:0]      rsp_x_reg;
  logic [W-1:0]      rsp_y_reg;
  logic              rsp_err_reg;

  // Unpacked views of the flattened operand buses
  logic [W-1:0] x_arr     [N_REQ];
  logic [W-1:0] y_arr     [N_REQ];
  logic [W-1:0] phase_arr [N_REQ];

  // Round-robin search: rotate valids so ptr sits at bit 0, take the
  // lowest set bit, then map the offset back to an absolute index.
  logic [2*N_REQ-1:0] valid_dbl;
  logic [N_REQ-1:0]   valid_rot;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_off;
  logic [ID_W:0]      grant_sum;
  logic [ID_W-1:0]    grant_id;
  logic               grant_ok;
  logic [ID_W-1:0]    ptr_wrap;

  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = N_REQ'(valid_dbl >> ptr_reg);

  // Priority pick of the first valid requester at or after ptr
  always_comb begin
    grant_valid = 1'b0;
    grant_off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_valid = 1'b1;
        grant_off   = ID_W'(k);
      end
    end
  end

  assign grant_sum = {1'b0, ptr_reg} + {1'b0, grant_off};
  assign grant_id  = (grant_sum >= SUM_N) ? ID_W'(grant_sum - SUM_N)
                                          : grant_sum[ID_W-1:0];
  // Grants only while idle and never while reset is asserted
  assign grant_ok  = RST_N && (state_reg == IDLE) && grant_valid;
  assign ptr_wrap  = (gid_reg == ID_LAST) ? '0 : gid_reg + 1'b1;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign x_arr[gi]     = req_x[gi*W +: W];
      assign y_arr[gi]     = req_y[gi*W +: W];
      assign phase_arr[gi] = req_phase[gi*W +: W];
      assign req_ready[gi] = grant_ok && (grant_id == ID_W'(gi));
    end
  endgenerate

  // Job sequencer: accept, start engine, wait with timeout, respond
  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      gid_reg       <= '0;
      cnt_reg       <= '0;
      cor_start_reg <= 1'b0;
      cor_x_reg     <= '0;
      cor_y_reg     <= '0;
      cor_phase_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_x_reg     <= '0;
      rsp_y_reg     <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      cor_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            cor_x_reg     <= x_arr[grant_id];
            cor_y_reg     <= y_arr[grant_id];
            cor_phase_reg <= phase_arr[grant_id];
            gid_reg       <= grant_id;
            cor_start_reg <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // A done arriving on the last allowed cycle still wins
          if (cor_done) begin
            rsp_x_reg     <= cor_xo;
            rsp_y_reg     <= cor_yo;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else if (cnt_reg == CNT_MAX) begin
            rsp_x_reg     <= '0;
            rsp_y_reg     <= '0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            ptr_reg       <= ptr_wrap;
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cor_start = cor_start_reg;
  assign cor_x     = cor_x_reg;
  assign cor_y     = cor_y_reg;
  assign cor_phase = cor_phase_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = gid_reg;
  assign rsp_x     = rsp_x_reg;
  assign rsp_y     = rsp_y_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Bench for cordic_rr_sched: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a job-level model.
module tb_cordic_rr_sched;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TMO = 64;

  logic            CLK_50M = 1'b0;
  logic            RST_N;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_x, req_y, req_phase;
  logic            cor_start;
  logic [W-1:0]    cor_x, cor_y, cor_phase;
  logic            cor_done;
  logic [W-1:0]    cor_xo, cor_yo;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_x, rsp_y;
  logic            rsp_err;
  logic            busy;

  cordic_rr_sched #(.N_REQ(N), .W(W), .TMO(TMO)) dut (
    .CLK_50M(CLK_50M), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_phase(req_phase),
    .cor_start(cor_start), .cor_x(cor_x), .cor_y(cor_y), .cor_phase(cor_phase),
    .cor_done(cor_done), .cor_xo(cor_xo), .cor_yo(cor_yo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
  );

  initial forever #5 CLK_50M = ~CLK_50M;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50M); #1;
  endtask

  task automatic to_neg();
    @(negedge CLK_50M); #1;
  endtask

  // ---------------- engine stand-in ----------------
  int          eng_lat  = 0;   // 0: never answers on its own
  bit          eng_rand = 0;
  logic        force_done = 1'b0;
  logic [15:0] fix_xo = 16'h0, fix_yo = 16'h0;
  int          eng_pend;
  logic        eng_s;

  initial begin
    eng_pend = 0;
    cor_done = 1'b0; cor_xo = '0; cor_yo = '0;
    forever begin
      @(negedge CLK_50M);
      eng_s = cor_start;
      @(posedge CLK_50M); #2;
      cor_done = force_done;
      if (eng_s) eng_pend = eng_lat;
      if (eng_pend > 0) begin
        if (eng_pend == 1) begin
          cor_done = 1'b1; cor_xo = fix_xo; cor_yo = fix_yo;
        end
        eng_pend--;
      end
      if (eng_rand) begin
        if ($urandom_range(4) == 0) cor_done = 1'b1;
        cor_xo = 16'($urandom); cor_yo = 16'($urandom);
      end
    end
  end

  // ---------------- job-level reference model ----------------
  bit          m_active = 0, m_has_rsp = 0, m_fresh = 0;
  int          m_age = 0, m_gid = 0, m_ptr = 0;
  logic [15:0] m_cx = 0, m_cy = 0, m_cp = 0, m_rx = 0, m_ry = 0;
  logic        m_re = 0;
  int          gq[$];
  int          pq[$];

  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Compare DUT against the model, then advance the model with this cycle's inputs
  always @(negedge CLK_50M) begin
    logic [N-1:0] exp_ready;
    int g;
    g = rr_pick(m_ptr, req_valid);
    exp_ready = '0;
    if (RST_N && !m_active && g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_active));
    chk("cor_start", 32'(cor_start), 32'(m_active && m_age == 1));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_active && m_has_rsp));
    if ((m_active && !m_has_rsp) || m_fresh) begin
      chk("cor_x", 32'(cor_x), 32'(m_cx));
      chk("cor_y", 32'(cor_y), 32'(m_cy));
      chk("cor_phase", 32'(cor_phase), 32'(m_cp));
    end
    if ((m_active && m_has_rsp) || m_fresh) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_active ? m_gid : 0));
      chk("rsp_x", 32'(rsp_x), 32'(m_rx));
      chk("rsp_y", 32'(rsp_y), 32'(m_ry));
      chk("rsp_err", 32'(rsp_err), 32'(m_re));
    end
    for (int k = 0; k < N; k++)
      if (req_valid[k] && req_ready[k]) gq.push_back(k);
    if (cor_start) pq.push_back(int'(cor_phase));
    if (rsp_valid && rsp_ready && RST_N)
      $display("[TB] rsp id=%0d x=%h y=%h err=%0d", rsp_id, rsp_x, rsp_y, rsp_err);

    m_fresh = 0;
    if (!RST_N) begin
      m_active = 0; m_has_rsp = 0; m_age = 0; m_gid = 0; m_ptr = 0;
      m_cx = 0; m_cy = 0; m_cp = 0; m_rx = 0; m_ry = 0; m_re = 0;
      m_fresh = 1;
    end else if (!m_active) begin
      if (g >= 0) begin
        m_active = 1; m_has_rsp = 0; m_age = 1; m_gid = g;
        m_cx = req_x[g*W +: W]; m_cy = req_y[g*W +: W]; m_cp = req_phase[g*W +: W];
      end
    end else if (m_has_rsp) begin
      if (rsp_ready) begin
        m_active = 0; m_has_rsp = 0; m_ptr = (m_gid + 1) % N;
      end
    end else begin
      // age 1 is the start cycle; ages 2..TMO+1 are the waiting window
      if (m_age >= 2) begin
        if (cor_done) begin
          m_has_rsp = 1; m_rx = cor_xo; m_ry = cor_yo; m_re = 0;
        end else if (m_age == TMO + 1) begin
          m_has_rsp = 1; m_rx = 0; m_ry = 0; m_re = 1;
        end
      end
      m_age++;
    end
  end

  // ---------------- directed helpers ----------------
  int          rc, rid;
  logic [15:0] rx, ry;
  logic        re;

  // Issue one job from a lone requester; rc is the cycle rsp_valid rose (transfer = cycle 0)
  task automatic do_job(input int id, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] ph, input int bound);
    rc = -1; rid = -1; rx = 0; ry = 0; re = 0;
    req_x[id*W +: W] = x; req_y[id*W +: W] = y; req_phase[id*W +: W] = ph;
    req_valid = '0; req_valid[id] = 1'b1;
    for (int c = 0; c < bound; c++) begin
      to_neg();
      if (c == 0) chk("job_grant", 32'(req_ready), 32'(4'b0001 << id));
      if (c == 1) chk("job_start", 32'(cor_start), 32'd1);
      if (rc < 0 && rsp_valid) begin
        rc = c; rid = int'(rsp_id); rx = rsp_x; ry = rsp_y; re = rsp_err;
      end
      tick();
      if (c == 0) req_valid = '0;
      if (rc >= 0 && rsp_ready) return;
    end
    n_tests++; n_fail++;
    $display("FAIL job_bound: got no completed response expected one within %0d cycles", bound);
  endtask

  task automatic wait_idle(input int bound);
    for (int c = 0; c < bound; c++) begin
      to_neg();
      if (!busy) begin tick(); return; end
      tick();
    end
    n_tests++; n_fail++;
    $display("FAIL idle_bound: got busy expected idle within %0d cycles", bound);
  endtask

  int exp_g[5] = '{0, 1, 2, 3, 0};
  int exp_p[5] = '{60, 45, 67, 33, 60};
  logic [N-1:0] acc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; req_valid = '0; req_x = '0; req_y = '0; req_phase = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    to_neg();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cor_x", 32'(cor_x), 32'd0);
    chk("rst_rsp_x", 32'(rsp_x), 32'd0);
    tick();
    RST_N = 1'b1;

    // Single request, done after three waiting cycles
    rsp_ready = 1'b1; eng_lat = 3; fix_xo = 16'h1234; fix_yo = 16'h5678;
    do_job(2, 16'd1, 16'd0, 16'd60, 40);
    chk("t1_latency", 32'(rc), 32'd5);
    chk("t1_id", 32'(rid), 32'd2);
    chk("t1_x", 32'(rx), 32'h1234);
    chk("t1_y", 32'(ry), 32'h5678);
    chk("t1_err", 32'(re), 32'd0);

    // Round-robin with all requesters permanently valid, from ptr 0
    RST_N = 1'b0; tick(); RST_N = 1'b1;
    gq.delete(); pq.delete(); eng_lat = 2;
    for (int k = 0; k < N; k++) begin
      req_x[k*W +: W] = 16'(k + 1); req_y[k*W +: W] = 16'(k + 7);
      req_phase[k*W +: W] = 16'(exp_p[k]);
    end
    req_valid = 4'hF;
    for (int c = 0; c < 80 && gq.size() < 5; c++) tick();
    req_valid = '0;
    wait_idle(40);
    chk("rr_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(exp_g[i]));
    for (int i = 0; i < 5 && i < pq.size(); i++) chk("rr_phase", 32'(pq[i]), 32'(exp_p[i]));

    // Timeout, then a normal job
    eng_lat = 0;
    do_job(1, 16'h0AAA, 16'h0BBB, 16'd90, 200);
    chk("tmo_latency", 32'(rc), 32'd66);
    chk("tmo_err", 32'(re), 32'd1);
    chk("tmo_x", 32'(rx), 32'd0);
    chk("tmo_y", 32'(ry), 32'd0);
    eng_lat = 4; fix_xo = 16'h0F0F; fix_yo = 16'hF0F0;
    do_job(3, 16'h0003, 16'h0004, 16'd45, 40);
    chk("after_tmo_latency", 32'(rc), 32'd6);
    chk("after_tmo_err", 32'(re), 32'd0);
    chk("after_tmo_x", 32'(rx), 32'h0F0F);

    // Done coincident with the last allowed waiting cycle
    eng_lat = TMO; fix_xo = 16'hBEEF; fix_yo = 16'hCAFE;
    do_job(0, 16'h0011, 16'h0022, 16'd33, 200);
    chk("coin_latency", 32'(rc), 32'd66);
    chk("coin_err", 32'(re), 32'd0);
    chk("coin_x", 32'(rx), 32'hBEEF);
    chk("coin_y", 32'(ry), 32'hCAFE);

    // Response backpressure, with requester 3 queued behind
    rsp_ready = 1'b0; eng_lat = 2; fix_xo = 16'h1111; fix_yo = 16'h2222;
    req_x[1*W +: W] = 16'h0101; req_phase[1*W +: W] = 16'd12;
    req_valid = 4'b0010;
    to_neg();
    chk("bp_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      to_neg();
      if (rsp_valid) break;
      tick();
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      tick(); to_neg();
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_x", 32'(rsp_x), 32'h1111);
    end
    tick(); rsp_ready = 1'b1;
    to_neg();
    chk("bp_hs_ready", 32'(req_ready), 32'd0);
    tick(); to_neg();
    chk("bp_next_grant", 32'(req_ready), 32'b1000);
    tick(); req_valid = '0;
    wait_idle(40);

    // Stray done in IDLE and ISSUE must not complete a job early
    eng_lat = 3; fix_xo = 16'h3333; fix_yo = 16'h4444;
    force_done = 1'b1; tick(); tick();
    req_valid = 4'b0001; rc = -1;
    for (int c = 0; c < 40; c++) begin
      to_neg();
      if (rsp_valid) begin rc = c; rx = rsp_x; break; end
      tick();
      if (c == 0) req_valid = '0;
      if (c == 1) force_done = 1'b0;
    end
    force_done = 1'b0;
    chk("stray_latency", 32'(rc), 32'd5);
    chk("stray_x", 32'(rx), 32'h3333);
    tick();
    wait_idle(40);

    // Reset during WAIT: job abandoned, pointer back to 0
    eng_lat = 2;
    do_job(2, 16'h0005, 16'h0006, 16'd7, 40);
    eng_lat = 0;
    req_valid = 4'b0100; tick();
    req_valid = '0; tick(); tick();
    RST_N = 1'b0; tick(); RST_N = 1'b1;
    to_neg();
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rw_cor_phase", 32'(cor_phase), 32'd0);
    chk("rw_rsp_id", 32'(rsp_id), 32'd0);
    tick();
    req_valid = 4'b1010;
    to_neg();
    chk("rw_ptr_grant", 32'(req_ready), 32'b0010);
    tick(); req_valid = '0; eng_lat = 3;
    wait_idle(40);

    // Randomized traffic with resets, backpressure and stray dones
    eng_lat = 0; eng_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      to_neg();
      acc = req_valid & req_ready;
      tick();
      for (int k = 0; k < N; k++) begin
        if (acc[k]) req_valid[k] = 1'b0;
        if (!req_valid[k] && $urandom_range(3) == 0) begin
          req_valid[k] = 1'b1;
          req_x[k*W +: W] = 16'($urandom); req_y[k*W +: W] = 16'($urandom);
          req_phase[k*W +: W] = 16'($urandom);
        end
      end
      rsp_ready = ($urandom_range(2) != 0);
      RST_N = ($urandom_range(299) != 0);
    end
    eng_rand = 0; req_valid = '0; RST_N = 1'b1; rsp_ready = 1'b1;
    wait_idle(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_rr_sched.md
# cordic_rr_sched

Round-robin scheduler that shares one CORDIC rotation engine between `N_REQ` DCT rotation requesters in the 8x8 1D DCT datapath. It accepts one rotation job (X, Y, Phase) at a time and sequences the engine with a start pulse. It then waits for the engine's done flag, with a timeout, and returns the rotated result on a single shared response channel tagged with the requester id. It sits between the DCT butterfly stages and the single `Cordic` instance.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 16: data width of X, Y and Phase.
- `TMO`, 64: maximum WAIT-state cycles before the job is aborted with an error, ≥2.

Ports:
- `CLK_50M`  in  1  clock, all logic on the rising edge.
- `RST_N`  in  1  reset, active-low, synchronous.
- `req_valid`  in  N_REQ  per-requester job valid.
- `req_ready`  out  N_REQ  one-hot grant/accept; a job transfers when `req_valid[i] & req_ready[i]`.
- `req_x`, `req_y`, `req_phase`  in  N_REQ*W each  flattened operands; requester i uses bits [i*W +: W].
- `cor_start`  out  1  one-cycle start pulse to the engine.
- `cor_x`, `cor_y`, `cor_phase`  out  W each  engine operands, held stable from ISSUE through WAIT.
- `cor_done`  in  1  engine result valid; sampled only in WAIT.
- `cor_xo`, `cor_yo`  in  W each  engine results.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  clog2(N_REQ)  granted requester index.
- `rsp_x`, `rsp_y`  out  W each  rotated result.
- `rsp_err`  out  1  job timed out; when set, `rsp_x` and `rsp_y` are 0.
- `busy`  out  1  high in every state other than IDLE.

## Operation
States: IDLE, ISSUE, WAIT, RESP. The state register, the round-robin pointer `ptr` and the WAIT counter `cnt` are registers.

IDLE:
- Grant goes to the first `i` with `req_valid[i]`, searching `ptr, ptr+1, …` mod N_REQ.
- `req_ready` is combinational and one-hot on the grant; it is 0 when no request is valid.
- On transfer, latch operands into `cor_x/y/phase`, latch `gid = i`, then go to ISSUE.

ISSUE:
- `cor_start = 1` for exactly this cycle.
- Clear `cnt` to 0, then go to WAIT.

WAIT:
- If `cor_done` is high, latch `cor_xo/cor_yo` into `rsp_x/rsp_y` and set `rsp_err = 0`, then go to RESP.
- Else, if `cnt == TMO-1`, set `rsp_x = rsp_y = 0` and `rsp_err = 1`, then go to RESP.
- Otherwise increment `cnt`.
- `cor_done` takes priority if it arrives in the same cycle the timeout would fire.

RESP:
- `rsp_valid = 1` and `rsp_id = gid`; the response is held stable until `rsp_ready`.
- When `rsp_ready` is seen, set `ptr = (gid+1) mod N_REQ`, deassert `rsp_valid` and go to IDLE.

General rules:
- `req_ready` is all-zero outside IDLE.
- Requests arriving outside IDLE wait; a requester must hold `req_valid` and its operands until accepted.
- `cor_done` in IDLE, ISSUE or RESP is ignored.
- Phase is passed through unmodified; the block does not interpret angle units.
- `cor_xo`/`cor_yo` go straight to `rsp_x`/`rsp_y` with no width change and no rounding.

## Timing
Reset: while `RST_N` is low at a clock edge, the block enters IDLE and the following are 0 on the next cycle:
- `ptr`, `cnt`, `gid`
- `cor_start`, `cor_x`, `cor_y`, `cor_phase`
- `rsp_valid`, `rsp_id`, `rsp_x`, `rsp_y`, `rsp_err`, `busy`

`req_ready` is forced to 0 during any cycle with `RST_N` low. A reset in any state abandons the job; no response is produced for it.

Cycle numbering for one job, with cycle 0 the IDLE transfer cycle:
- Cycle 1: `cor_start` is high.
- If `cor_done` first arrives in cycle 1+k (k≥1), `rsp_valid` rises in cycle 2+k.
- Timeout with no done: `rsp_valid` rises in cycle 2+TMO with `rsp_err = 1`.

Throughput:
- The next grant can occur in the cycle after the `rsp_valid & rsp_ready` handshake.
- Minimum job period is k+3 cycles when `rsp_ready` is held high.

## Test plan
- Single request, engine done after 3 WAIT cycles. Requester 2 sends X=1, Y=0, Phase=60; engine returns xo=0x1234, yo=0x5678 → `cor_start` at cycle 1; `rsp_valid` at cycle 5 with `rsp_id=2`, `rsp_x=0x1234`, `rsp_y=0x5678`, `rsp_err=0`.
- Round-robin fairness. All four `req_valid` held high, `rsp_ready=1`, phases 60/45/67/33 → grants in the order 0,1,2,3,0. Each `cor_phase` matches its requester. `req_ready` is never more than one-hot.
- Timeout, TMO=64, `cor_done` never asserted → `rsp_valid` at cycle 66 with `rsp_err=1` and `rsp_x=rsp_y=0`. The next job then completes normally.
- Response backpressure. `rsp_ready` held low for 10 cycles → `rsp_valid`, `rsp_id`, `rsp_x` and `rsp_y` stay constant and `req_ready` stays 0. The next grant occurs one cycle after `rsp_ready` rises.
- Reset mid-WAIT. Pull `RST_N` low for 1 cycle at WAIT cycle 2 → all outputs are 0 the next cycle and no response is emitted. A new request afterwards is granted starting from `ptr=0`.
- Stray and coincident done:
  - `cor_done` pulsed in IDLE and in ISSUE → ignored.
  - `cor_done` in the same cycle as `cnt == TMO-1` → `rsp_err = 0` and the result is latched.
